sample_slot_sequencer: RTL and testbench

Parametrised sample-slot timing generator for the EEPROM data logger. A prescaler divides `clk` by a runtime-loadable period, and each period advances a slot index through `NUM_SLOTS` positions. The block runs in continuous or one-shot frame mode, with start/stop/pause control and per-slot and per-frame pulses. It sits between the system clock and the sampling/EEPROM write scheduler, and is the generalised successor of the fixed 64-slot sample counter timer.

---
 rtl/sample_slot_sequencer.sv | 96 +++++++++
 tb/tb_sample_slot_sequencer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/sample_slot_sequencer.sv
// Sample-slot timing generator: a runtime-loadable prescaler steps a slot index
// through NUM_SLOTS positions per frame, in continuous or one-shot frame mode.
//
// state | meaning
// IDLE  | stopped; threshold may be loaded, waits for start
// RUN   | prescaler counting, slot advancing while enable is high
module sample_slot_sequencer #(
    parameter int CNT_W             = 32,
    parameter int NUM_SLOTS         = 64,
    parameter int SLOT_W            = 6,
    parameter int DEFAULT_THRESHOLD = 8192
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              enable,
    input  logic              oneshot,
    input  logic              load_thr,
    input  logic [CNT_W-1:0]  thr_in,
    output logic [SLOT_W-1:0] slot,
    output logic              tick,
    output logic              frame_done,
    output logic              busy,
    output logic [CNT_W-1:0]  thr
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);
    localparam logic [CNT_W-1:0]  THR_RST   = CNT_W'(DEFAULT_THRESHOLD);

    logic             state;
    logic             mode;
    logic [CNT_W-1:0] counter;

    // state is itself a flop, so busy stays a registered output
    assign busy = (state == ST_RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            mode       <= 1'b0;
            counter    <= '0;
            slot       <= '0;
            tick       <= 1'b0;
            frame_done <= 1'b0;
            thr        <= THR_RST;
        end else begin
            tick       <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (load_thr) begin
                        thr <= thr_in;
                    end
                    if (start) begin
                        state   <= ST_RUN;
                        counter <= '0;
                        slot    <= '0;
                        mode    <= oneshot;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state   <= ST_IDLE;
                        counter <= '0;
                        slot    <= '0;
                    end else if (enable) begin
                        // thr is frozen in RUN, so equality is a safe terminal count
                        if (counter == thr) begin
                            counter <= '0;
                            tick    <= 1'b1;
                            if (slot == LAST_SLOT) begin
                                slot       <= '0;
                                frame_done <= 1'b1;
                                if (mode) begin
                                    state <= ST_IDLE;
                                end
                            end else begin
                                slot <= slot + SLOT_W'(1);
                            end
                        end else begin
                            counter <= counter + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sample_slot_sequencer.sv
// Self-checking bench for sample_slot_sequencer (NUM_SLOTS=4): vector table
// plus continuous-frame and pause/stop sequences, checked through a scoreboard.
module tb_sample_slot_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, stop, enable, oneshot, load_thr;
    logic [31:0] thr_in;
    logic [1:0]  slot;
    logic        tick, frame_done, busy;
    logic [31:0] thr;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [1:0]  slot;
        logic        tick;
        logic        fd;
        logic        busy;
        logic [31:0] thr;
    } exp_t;

    typedef struct {
        logic        rst, start, stop, en, os, ld;
        logic [31:0] thr_in;
        exp_t        exp;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[27];

    sample_slot_sequencer #(
        .CNT_W(32), .NUM_SLOTS(4), .SLOT_W(2), .DEFAULT_THRESHOLD(8192)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .enable(enable),
        .oneshot(oneshot), .load_thr(load_thr), .thr_in(thr_in),
        .slot(slot), .tick(tick), .frame_done(frame_done), .busy(busy), .thr(thr)
    );

    always #5 clk = ~clk;

    function automatic exp_t mke(input logic [1:0] s, input logic t, input logic f,
                                 input logic b, input logic [31:0] th);
        exp_t e;
        e.slot = s; e.tick = t; e.fd = f; e.busy = b; e.thr = th;
        return e;
    endfunction

    function automatic vec_t mkv(input logic r, input logic s, input logic p, input logic e,
                                 input logic o, input logic l, input logic [31:0] ti, input exp_t ex);
        vec_t v;
        v.rst = r; v.start = s; v.stop = p; v.en = e; v.os = o; v.ld = l;
        v.thr_in = ti; v.exp = ex;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", tag, act, req);
        end
    endtask

    // Apply one cycle of inputs, queue its expectation, compare just after the edge.
    task automatic step(input logic r, input logic s, input logic p, input logic e,
                        input logic o, input logic l, input logic [31:0] ti,
                        input exp_t ex, input string tag);
        exp_t got;
        rst = r; start = s; stop = p; enable = e; oneshot = o; load_thr = l; thr_in = ti;
        sb.push_back(ex);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk({tag, " slot"}, 32'(slot), 32'(got.slot));
        chk({tag, " tick"}, 32'(tick), 32'(got.tick));
        chk({tag, " frame_done"}, 32'(frame_done), 32'(got.fd));
        chk({tag, " busy"}, 32'(busy), 32'(got.busy));
        chk({tag, " thr"}, thr, got.thr);
    endtask

    initial begin
        int en_cnt;
        logic e;
        logic t;
        //                 rst st sp en os ld thr_in     slot tick fd busy thr
        vecs[0]  = mkv(1, 0, 0, 0, 0, 0, 0,  mke(0, 0, 0, 0, 8192)); // reset
        vecs[1]  = mkv(1, 0, 0, 0, 0, 0, 0,  mke(0, 0, 0, 0, 8192));
        vecs[2]  = mkv(0, 0, 0, 0, 0, 0, 0,  mke(0, 0, 0, 0, 8192));
        vecs[3]  = mkv(0, 0, 0, 0, 0, 1, 0,  mke(0, 0, 0, 0, 0));    // load thr=0
        vecs[4]  = mkv(0, 1, 0, 1, 1, 0, 0,  mke(0, 0, 0, 1, 0));    // one-shot start
        vecs[5]  = mkv(0, 0, 0, 1, 0, 0, 0,  mke(1, 1, 0, 1, 0));
        vecs[6]  = mkv(0, 0, 0, 1, 0, 0, 0,  mke(2, 1, 0, 1, 0));
        vecs[7]  = mkv(0, 0, 0, 1, 0, 0, 0,  mke(3, 1, 0, 1, 0));
        vecs[8]  = mkv(0, 0, 0, 1, 0, 0, 0,  mke(0, 1, 1, 0, 0));    // wrap ends frame
        vecs[9]  = mkv(0, 1, 0, 1, 1, 0, 0,  mke(0, 0, 0, 1, 0));    // immediate restart
        vecs[10] = mkv(0, 0, 0, 1, 0, 0, 0,  mke(1, 1, 0, 1, 0));
        vecs[11] = mkv(0, 0, 1, 1, 0, 0, 0,  mke(0, 0, 0, 0, 0));    // stop beats advance
        vecs[12] = mkv(0, 0, 1, 0, 0, 0, 0,  mke(0, 0, 0, 0, 0));    // stop in idle
        vecs[13] = mkv(0, 1, 1, 0, 0, 0, 0,  mke(0, 0, 0, 1, 0));    // start wins in idle
        vecs[14] = mkv(0, 0, 0, 1, 0, 1, 7,  mke(1, 1, 0, 1, 0));    // load ignored in run
        vecs[15] = mkv(0, 1, 0, 0, 0, 0, 0,  mke(1, 0, 0, 1, 0));    // start in run, paused
        vecs[16] = mkv(0, 0, 0, 0, 0, 0, 0,  mke(1, 0, 0, 1, 0));
        vecs[17] = mkv(0, 0, 0, 1, 0, 0, 0,  mke(2, 1, 0, 1, 0));
        vecs[18] = mkv(1, 0, 0, 1, 0, 0, 0,  mke(0, 0, 0, 0, 8192)); // reset mid-run
        vecs[19] = mkv(0, 1, 0, 1, 0, 1, 2,  mke(0, 0, 0, 1, 2));    // load+start together
        vecs[20] = mkv(0, 0, 0, 1, 0, 0, 0,  mke(0, 0, 0, 1, 2));
        vecs[21] = mkv(0, 0, 0, 1, 0, 0, 0,  mke(0, 0, 0, 1, 2));
        vecs[22] = mkv(0, 0, 0, 1, 0, 0, 0,  mke(1, 1, 0, 1, 2));    // tick 3 after busy
        vecs[23] = mkv(0, 0, 1, 1, 0, 0, 0,  mke(0, 0, 0, 0, 2));
        vecs[24] = mkv(0, 1, 0, 1, 0, 1, 5,  mke(0, 0, 0, 1, 5));
        vecs[25] = mkv(0, 0, 0, 1, 0, 0, 0,  mke(0, 0, 0, 1, 5));
        vecs[26] = mkv(1, 0, 0, 1, 0, 0, 0,  mke(0, 0, 0, 0, 8192)); // reset drops thr

        rst = 1'b1; start = 1'b0; stop = 1'b0; enable = 1'b0;
        oneshot = 1'b0; load_thr = 1'b0; thr_in = '0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 27; i++) begin
            step(vecs[i].rst, vecs[i].start, vecs[i].stop, vecs[i].en, vecs[i].os,
                 vecs[i].ld, vecs[i].thr_in, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Continuous mode, thr=3: tick every 4 cycles, frame_done every 16.
        step(0, 0, 0, 0, 0, 1, 3, mke(0, 0, 0, 0, 3), "cont load");
        step(0, 1, 0, 1, 0, 0, 0, mke(0, 0, 0, 1, 3), "cont start");
        for (int c = 1; c <= 40; c++) begin
            t = (c % 4 == 0);
            step(0, 0, 0, 1, 0, 0, 0,
                 mke(2'((c / 4) % 4), t, t && ((c / 4) % 4 == 0), 1, 3),
                 $sformatf("cont c%0d", c));
        end
        step(0, 0, 1, 1, 0, 0, 0, mke(0, 0, 0, 0, 3), "cont stop");

        // Pause 5 cycles mid-slot, then stop on the cycle counter reaches thr.
        step(0, 1, 0, 1, 0, 0, 0, mke(0, 0, 0, 1, 3), "pause start");
        en_cnt = 0;
        for (int k = 1; k <= 12; k++) begin
            e = !(k >= 3 && k <= 7);
            if (e) en_cnt++;
            t = e && (en_cnt % 4 == 0);
            step(0, 0, 0, e, 0, 0, 0, mke(2'((en_cnt / 4) % 4), t, 0, 1, 3),
                 $sformatf("pause k%0d", k));
        end
        step(0, 0, 1, 1, 0, 0, 0, mke(0, 0, 0, 0, 3), "stop at terminal");
        step(0, 0, 0, 1, 0, 0, 0, mke(0, 0, 0, 0, 3), "idle after stop");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
